pico_irq_ctrl: RTL and testbench

- Interrupt controller that shares the single KCPSM6 `interrupt` input among up to 8 external sources.
- Synchronises and edge-detects the sources, then holds them as pending flags.
- Sequences the `interrupt`/`interrupt_ack` handshake and serves one source at a time until software writes end-of-interrupt (EOI).
- Attaches to the processor's port bus (`port_id`, `out_port`, `write_strobe`, `read_strobe`). It supplies `in_port` data for its own address window; the top level multiplexes that data with the other peripherals.

---
 rtl/pico_irq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pico_irq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pico_irq_ctrl.sv
// ============================================================================
// pico_irq_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the single KCPSM6 `interrupt` input among up to NUM_SRC external
//   sources. Raw sources are synchronised, edge-detected and latched as
//   pending flags. Qualified (pending & mask) sources are served one at a
//   time, lowest index first, through the interrupt/interrupt_ack handshake.
//   Service ends when software writes the EOI register.
//
// Register window (offsets from BASE_PORT):
//   +0 STATUS  R: pending flags          W: write-1-to-clear
//   +1 MASK    R/W: 1 = source enabled
//   +2 ID      R: {cur_valid, 4'b0, cur_id[2:0]}
//   +3 EOI     W: any data ends service (only while in service)
//   +4 SWSET   W: ORs out_port into pending
//
// Ports:
//   clk            system clock, rising edge
//   cpu_reset_n    asynchronous active-low reset
//   irq_src        raw asynchronous interrupt sources (rising edge = event)
//   port_id        KCPSM6 port address
//   out_port       KCPSM6 write data
//   write_strobe   KCPSM6 OUTPUT strobe
//   read_strobe    KCPSM6 INPUT strobe (reads have no side effects)
//   interrupt_ack  KCPSM6 interrupt acknowledge
//   interrupt      to KCPSM6 interrupt input
//   in_data        registered read data, 8'h00 outside the window
//   in_sel         registered, 1 when previous port_id was in the window
// ============================================================================
module pico_irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [7:0]  BASE_PORT = 8'h40
) (
    input  logic               clk,
    input  logic               cpu_reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    input  logic               interrupt_ack,
    output logic               interrupt,
    output logic [7:0]         in_data,
    output logic               in_sel
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [NUM_SRC-1:0]   r_sync1;
    logic [NUM_SRC-1:0]   r_sync2;
    logic [NUM_SRC-1:0]   r_dly;
    logic [NUM_SRC-1:0]   r_rise;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_mask;
    logic [2:0]           r_cur_id;
    logic                 r_cur_valid;
    logic                 r_interrupt;
    logic [7:0]           r_in_data;
    logic                 r_in_sel;

    logic [7:0]           w_offset;
    logic                 w_in_window;
    logic                 w_wr_status;
    logic                 w_wr_mask;
    logic                 w_wr_eoi;
    logic                 w_wr_swset;
    logic [NUM_SRC-1:0]   w_qual;
    logic                 w_qual_any;
    logic [2:0]           w_winner;
    logic                 w_ack_take;
    logic                 w_eoi_take;
    logic [NUM_SRC-1:0]   w_ack_clr;
    logic [NUM_SRC-1:0]   w_set;
    logic [NUM_SRC-1:0]   w_clr;
    logic [7:0]           w_pend8;
    logic [7:0]           w_mask8;
    logic [7:0]           w_rd_mux;
    logic                 w_unused;

    // read_strobe is not needed: read data is registered every cycle.
    assign w_unused = read_strobe;

    // Offset by subtraction so the window decode also works near 8'hFF.
    assign w_offset    = port_id - BASE_PORT;
    assign w_in_window = (w_offset <= 8'd4);
    assign w_wr_status = write_strobe && (w_offset == 8'd0);
    assign w_wr_mask   = write_strobe && (w_offset == 8'd1);
    assign w_wr_eoi    = write_strobe && (w_offset == 8'd3);
    assign w_wr_swset  = write_strobe && (w_offset == 8'd4);

    assign w_qual      = r_pending & r_mask;
    assign w_qual_any  = |w_qual;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        w_winner = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ack_take   = 1'b0;
        w_eoi_take   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_qual_any) begin
                    w_next_state = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // Losing all qualified sources takes precedence over an ack,
                // so cur_id can never latch a source that is not pending.
                if (!w_qual_any) begin
                    w_next_state = S_IDLE;
                end else if (interrupt_ack) begin
                    w_next_state = S_SERVICE;
                    w_ack_take   = 1'b1;
                end
            end
            S_SERVICE: begin
                if (w_wr_eoi) begin
                    w_next_state = S_IDLE;
                    w_eoi_take   = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ack_clr = '0;
        if (w_ack_take) begin
            w_ack_clr[w_winner] = 1'b1;
        end
    end

    // Sets are ORed in after clears so a coincident new edge wins.
    assign w_set = r_rise | (w_wr_swset ? out_port[NUM_SRC-1:0] : '0);
    assign w_clr = w_ack_clr | (w_wr_status ? out_port[NUM_SRC-1:0] : '0);

    assign w_pend8 = 8'(r_pending);
    assign w_mask8 = 8'(r_mask);

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_offset)
            8'd0:    w_rd_mux = w_pend8;
            8'd1:    w_rd_mux = w_mask8;
            8'd2:    w_rd_mux = {r_cur_valid, 4'b0000, r_cur_id};
            default: w_rd_mux = 8'h00;
        endcase
    end

    // Two-flop synchroniser, delay flop and registered rise detect. A source
    // high at reset release looks like a rising edge because r_dly starts 0.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dly   <= '0;
            r_rise  <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
            r_rise  <= r_sync2 & ~r_dly;
        end
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_wr_mask) begin
                r_mask <= out_port[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state     <= S_IDLE;
            r_interrupt <= 1'b0;
            r_cur_id    <= 3'd0;
            r_cur_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_interrupt <= (w_next_state == S_ASSERT);
            if (w_ack_take) begin
                r_cur_id    <= w_winner;
                r_cur_valid <= 1'b1;
            end else if (w_eoi_take) begin
                r_cur_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_in_data <= 8'h00;
            r_in_sel  <= 1'b0;
        end else begin
            r_in_data <= w_in_window ? w_rd_mux : 8'h00;
            r_in_sel  <= w_in_window;
        end
    end

    assign interrupt = r_interrupt;
    assign in_data   = r_in_data;
    assign in_sel    = r_in_sel;

endmodule

// File: tb/tb_pico_irq_ctrl.sv
// ============================================================================
// tb_pico_irq_ctrl
// ----------------------------------------------------------------------------
// Directed bench for pico_irq_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// ============================================================================
module tb_pico_irq_ctrl;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk = 1'b0;
    logic       cpu_reset_n;
    logic [7:0] irq_src;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] in_data;
    logic       in_sel;

    int checks = 0;
    int errors = 0;

    pico_irq_ctrl #(
        .NUM_SRC   (8),
        .BASE_PORT (BASE)
    ) dut (
        .clk           (clk),
        .cpu_reset_n   (cpu_reset_n),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
        .in_data       (in_data),
        .in_sel        (in_sel)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-clock pulse on the selected sources.
    task automatic applyStimulus(input logic [7:0] srcBits);
        irq_src = srcBits;
        tick(1);
        irq_src = 8'h00;
    endtask

    task automatic writeReg(input logic [7:0] offset, input logic [7:0] data);
        port_id      = BASE + offset;
        out_port     = data;
        write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0;
    endtask

    task automatic readReg(input string tag, input logic [7:0] offset,
                           input logic [7:0] expected);
        port_id     = BASE + offset;
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
        checkOutput(tag, in_data, expected);
        checkOutput({tag, "_sel"}, {7'b0, in_sel}, 8'h01);
    endtask

    task automatic ackPulse();
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
    endtask

    initial begin
        cpu_reset_n   = 1'b0;
        irq_src       = 8'h00;
        port_id       = 8'h00;
        out_port      = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;

        // Reset state
        tick(2);
        checkOutput("rst_int", {7'b0, interrupt}, 8'h00);
        checkOutput("rst_data", in_data, 8'h00);
        checkOutput("rst_sel", {7'b0, in_sel}, 8'h00);
        cpu_reset_n = 1'b1;
        tick(1);
        readReg("rst_status", 8'd0, 8'h00);
        readReg("rst_mask", 8'd1, 8'h00);
        readReg("rst_id", 8'd2, 8'h00);
        writeReg(8'd1, 8'h01);
        readReg("mask_rb", 8'd1, 8'h01);
        port_id = 8'h10;
        tick(1);
        checkOutput("outside_data", in_data, 8'h00);
        checkOutput("outside_sel", {7'b0, in_sel}, 8'h00);

        // Single source: 5-clock latency, hold until ack
        writeReg(8'd1, 8'h04);
        applyStimulus(8'h04);
        checkOutput("lat_e1", {7'b0, interrupt}, 8'h00);
        tick(3);
        checkOutput("lat_e4", {7'b0, interrupt}, 8'h00);
        tick(1);
        checkOutput("lat_e5", {7'b0, interrupt}, 8'h01);
        tick(3);
        checkOutput("hold", {7'b0, interrupt}, 8'h01);
        ackPulse();
        checkOutput("ack_drop", {7'b0, interrupt}, 8'h00);
        readReg("id_src2", 8'd2, 8'h82);
        readReg("status_clr2", 8'd0, 8'h00);
        writeReg(8'd3, 8'h00);

        // Two simultaneous sources served in priority order
        writeReg(8'd1, 8'hFF);
        applyStimulus(8'h22);
        tick(4);
        checkOutput("two_int", {7'b0, interrupt}, 8'h01);
        ackPulse();
        checkOutput("two_ack1", {7'b0, interrupt}, 8'h00);
        readReg("id_src1", 8'd2, 8'h81);
        readReg("status_left5", 8'd0, 8'h20);
        checkOutput("svc_quiet", {7'b0, interrupt}, 8'h00);
        writeReg(8'd3, 8'h00);
        checkOutput("eoi_plus1", {7'b0, interrupt}, 8'h00);
        tick(1);
        checkOutput("eoi_plus2", {7'b0, interrupt}, 8'h01);
        ackPulse();
        readReg("id_src5", 8'd2, 8'h85);
        readReg("status_empty", 8'd0, 8'h00);
        writeReg(8'd3, 8'h00);

        // Software set, masking and clear before ack
        writeReg(8'd1, 8'h00);
        writeReg(8'd4, 8'h08);
        readReg("swset_status", 8'd0, 8'h08);
        tick(2);
        checkOutput("swset_masked", {7'b0, interrupt}, 8'h00);
        writeReg(8'd1, 8'h08);
        tick(1);
        checkOutput("unmask_int", {7'b0, interrupt}, 8'h01);
        writeReg(8'd0, 8'h08);
        tick(1);
        checkOutput("w1c_drop", {7'b0, interrupt}, 8'h00);
        readReg("w1c_status", 8'd0, 8'h00);
        ackPulse();
        tick(1);
        checkOutput("idle_ack_int", {7'b0, interrupt}, 8'h00);
        readReg("idle_ack_id", 8'd2, 8'h05);

        // New edges on the source in service
        writeReg(8'd1, 8'h01);
        applyStimulus(8'h01);
        tick(4);
        checkOutput("src0_int", {7'b0, interrupt}, 8'h01);
        ackPulse();
        readReg("src0_id", 8'd2, 8'h80);
        applyStimulus(8'h01);
        tick(5);
        checkOutput("svc_edge_int", {7'b0, interrupt}, 8'h00);
        readReg("svc_edge_status", 8'd0, 8'h01);
        writeReg(8'd3, 8'h00);
        tick(1);
        checkOutput("svc_edge_reassert", {7'b0, interrupt}, 8'h01);
        // Edge lands in pending on the same clock as the ack
        irq_src = 8'h01;
        tick(1);
        irq_src = 8'h00;
        tick(2);
        ackPulse();
        checkOutput("coinc_int", {7'b0, interrupt}, 8'h00);
        readReg("coinc_status", 8'd0, 8'h01);
        readReg("coinc_id", 8'd2, 8'h80);
        writeReg(8'd3, 8'h00);
        tick(1);
        checkOutput("coinc_reassert", {7'b0, interrupt}, 8'h01);

        // Asynchronous reset mid-handshake
        #1;
        cpu_reset_n = 1'b0;
        #1;
        checkOutput("async_int", {7'b0, interrupt}, 8'h00);
        checkOutput("async_sel", {7'b0, in_sel}, 8'h00);
        tick(2);
        cpu_reset_n = 1'b1;
        tick(1);
        ackPulse();
        checkOutput("post_rst_ack", {7'b0, interrupt}, 8'h00);
        readReg("post_rst_status", 8'd0, 8'h00);
        readReg("post_rst_mask", 8'd1, 8'h00);
        readReg("post_rst_id", 8'd2, 8'h00);

        // Source held high across reset release
        cpu_reset_n = 1'b0;
        irq_src     = 8'h08;
        tick(2);
        cpu_reset_n = 1'b1;
        tick(3);
        readReg("held_e4", 8'd0, 8'h00);
        readReg("held_e5", 8'd0, 8'h08);
        irq_src = 8'h00;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
